// File: rtl/paddle_control.sv
// Two-channel Pong paddle mover driven by held-key levels and frame ticks.
// Speed doubles after a sustained hold; positions clamp to the playfield.
module paddle_control #(
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_H   = 80,
    parameter int STEP       = 4,
    parameter int FAST_STEP  = 8,
    parameter int HOLD_TICKS = 15
) (
    input  logic       paddle_control_clk,
    input  logic       paddle_control_rst_n,
    input  logic [3:0] paddle_control_keys,
    input  logic       paddle_control_tick,
    input  logic       paddle_control_enable,
    input  logic       paddle_control_center,
    output logic [9:0] paddle_control_left_y,
    output logic [9:0] paddle_control_right_y,
    output logic       paddle_control_left_moving,
    output logic       paddle_control_right_moving
);

    localparam int CENTER = (SCREEN_H - PADDLE_H) / 2;
    localparam int MAXY   = SCREEN_H - PADDLE_H;
    localparam int CW     = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

    typedef struct packed {
        dir_t          st;
        logic [CW-1:0] cnt;
        logic [9:0]    y;
    } chan_t;

    logic [3:0] r_keys_q;
    chan_t      r_left;
    chan_t      r_right;
    chan_t      w_left_nxt;
    chan_t      w_right_nxt;

    function automatic chan_t chan_next(
        input chan_t cur,
        input logic  up,
        input logic  dn,
        input logic  center,
        input logic  enable,
        input logic  tick
    );
        chan_t       n;
        dir_t        req;
        logic [10:0] step;
        logic [10:0] sum;
        n    = cur;
        step = 11'(STEP);
        sum  = '0;
        if (up && !dn) begin
            req = UP;
        end else if (dn && !up) begin
            req = DOWN;
        end else begin
            req = IDLE;
        end
        if (center) begin
            n.st  = IDLE;
            n.cnt = '0;
            n.y   = 10'(CENTER);
        end else if (!enable) begin
            n.st  = IDLE;
            n.cnt = '0;
        end else if (tick) begin
            if (req == IDLE) begin
                n.st  = IDLE;
                n.cnt = '0;
            end else begin
                if (req != cur.st) begin
                    n.cnt = CW'(1);
                end else if (cur.cnt == CW'(HOLD_TICKS)) begin
                    step = 11'(FAST_STEP);
                end else begin
                    n.cnt = cur.cnt + CW'(1);
                end
                n.st = req;
                // 11-bit math: a negative result shows up as bit 10 set
                if (req == UP) begin
                    sum = {1'b0, cur.y} - step;
                    n.y = sum[10] ? 10'd0 : sum[9:0];
                end else begin
                    sum = {1'b0, cur.y} + step;
                    n.y = (sum > 11'(MAXY)) ? 10'(MAXY) : sum[9:0];
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        w_left_nxt  = r_left;
        w_right_nxt = r_right;
        w_left_nxt  = chan_next(r_left, r_keys_q[2], r_keys_q[3],
                                paddle_control_center,
                                paddle_control_enable,
                                paddle_control_tick);
        w_right_nxt = chan_next(r_right, r_keys_q[0], r_keys_q[1],
                                paddle_control_center,
                                paddle_control_enable,
                                paddle_control_tick);
    end

    always_ff @(posedge paddle_control_clk) begin
        if (!paddle_control_rst_n) begin
            r_keys_q    <= '0;
            r_left.st   <= IDLE;
            r_left.cnt  <= '0;
            r_left.y    <= 10'(CENTER);
            r_right.st  <= IDLE;
            r_right.cnt <= '0;
            r_right.y   <= 10'(CENTER);
        end else begin
            r_keys_q <= paddle_control_keys;
            r_left   <= w_left_nxt;
            r_right  <= w_right_nxt;
        end
    end

    assign paddle_control_left_y       = r_left.y;
    assign paddle_control_right_y      = r_right.y;
    assign paddle_control_left_moving  = (r_left.st != IDLE);
    assign paddle_control_right_moving = (r_right.st != IDLE);

endmodule
